// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg: shared operation classes, control codes and sequencer
// state encoding for the registered ALU control sequencer.
package alu_ctrl_pkg;

  localparam int OP_ADD   = 0;
  localparam int OP_SUB   = 1;
  localparam int OP_RTYPE = 2;
  localparam int OP_SHIFT = 3;
  localparam int OP_OP4   = 4;

  localparam int CTL_ADD = 0;
  localparam int CTL_SUB = 1;
  localparam int CTL_SHR = 6;
  localparam int CTL_SHL = 7;
  localparam int CTL_OP4 = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/alu_ctrl_seq_if.sv
// alu_ctrl_seq_if: operation handshake from ID/EX and control/sequencing
// outputs toward the ALU and iterative shifter.
interface alu_ctrl_seq_if #(
  parameter int OP_W    = 3,
  parameter int FUNC_W  = 3,
  parameter int CTRL_W  = 4,
  parameter int SHAMT_W = 4
);
  logic               inValid;
  logic               inReady;
  logic [OP_W-1:0]    aluOp;
  logic [FUNC_W-1:0]  func;
  logic               shiftDirection;
  logic [SHAMT_W-1:0] shamt;
  logic               stall;
  logic               flush;
  logic               outValid;
  logic [CTRL_W-1:0]  aluControl;
  logic               shiftStep;
  logic               lastStep;
  logic               busy;
  logic               illegalOp;

  modport master (
    output inValid, aluOp, func, shiftDirection, shamt, stall, flush,
    input  inReady, outValid, aluControl, shiftStep, lastStep, busy, illegalOp
  );

  modport slave (
    input  inValid, aluOp, func, shiftDirection, shamt, stall, flush,
    output inReady, outValid, aluControl, shiftStep, lastStep, busy, illegalOp
  );
endinterface

// File: rtl/alu_ctrl_decode.sv
// alu_ctrl_decode: combinational aluOp/func/direction to control code,
// with an illegal-class flag for aluOp values beyond the defined set.
module alu_ctrl_decode
  import alu_ctrl_pkg::*;
#(
  parameter int OP_W   = 3,
  parameter int FUNC_W = 3,
  parameter int CTRL_W = 4
) (
  input  logic [OP_W-1:0]   i_alu_op,
  input  logic [FUNC_W-1:0] i_func,
  input  logic              i_shift_dir,
  output logic [CTRL_W-1:0] o_ctrl,
  output logic              o_illegal
);

  // decode operation class; unknown classes map to zero and raise the flag
  always_comb begin
    o_ctrl    = '0;
    o_illegal = 1'b0;
    if (i_alu_op == OP_W'(OP_ADD)) begin
      o_ctrl = CTRL_W'(CTL_ADD);
    end else if (i_alu_op == OP_W'(OP_SUB)) begin
      o_ctrl = CTRL_W'(CTL_SUB);
    end else if (i_alu_op == OP_W'(OP_RTYPE)) begin
      o_ctrl = CTRL_W'(i_func);
    end else if (i_alu_op == OP_W'(OP_SHIFT)) begin
      o_ctrl = i_shift_dir ? CTRL_W'(CTL_SHR) : CTRL_W'(CTL_SHL);
    end else if (i_alu_op == OP_W'(OP_OP4)) begin
      o_ctrl = CTRL_W'(CTL_OP4);
    end else begin
      o_illegal = 1'b1;
    end
  end

endmodule

// File: rtl/alu_ctrl_seq.sv
// alu_ctrl_seq: registered ALU control with valid/ready intake, stall,
// flush and a sequencer that expands an N-bit shift into N one-bit beats.
// Optional sticky illegal-op trap: define ALU_CTRL_SEQ_ILLEGAL_TRAP_EN.
//
//   state | meaning
//   IDLE  | accepting ops; shows the beat of the last single-beat op (or none)
//   SHIFT | emitting shift beats; r_cnt = beats remaining including current
module alu_ctrl_seq
  import alu_ctrl_pkg::*;
#(
  parameter int OP_W    = 3,
  parameter int FUNC_W  = 3,
  parameter int CTRL_W  = 4,
  parameter int SHAMT_W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  alu_ctrl_seq_if.slave bus
);

  state_t              r_state, w_nxt_state;
  logic [SHAMT_W-1:0]  r_cnt, w_nxt_cnt;
  logic                r_out_valid, w_nxt_valid;
  logic [CTRL_W-1:0]   r_alu_ctrl, w_nxt_ctrl;
  logic                r_shift_step, w_nxt_shift;
  logic                r_last_step, w_nxt_last;
  logic                r_busy, w_nxt_busy;

  logic [CTRL_W-1:0]   w_dec_ctrl;
  logic                w_dec_illegal;
  logic                w_in_ready;
  logic                w_accept;
  logic                w_is_shift;

  alu_ctrl_decode #(
    .OP_W   (OP_W),
    .FUNC_W (FUNC_W),
    .CTRL_W (CTRL_W)
  ) u_decode (
    .i_alu_op    (bus.aluOp),
    .i_func      (bus.func),
    .i_shift_dir (bus.shiftDirection),
    .o_ctrl      (w_dec_ctrl),
    .o_illegal   (w_dec_illegal)
  );

  assign w_in_ready = rst_n && (r_state == IDLE) && !bus.stall && !bus.flush;
  assign w_accept   = bus.inValid && w_in_ready;
  assign w_is_shift = (bus.aluOp == OP_W'(OP_SHIFT));

  // next-state and next-output selection: flush > stall > accept/sequence
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_cnt   = r_cnt;
    w_nxt_valid = r_out_valid;
    w_nxt_ctrl  = r_alu_ctrl;
    w_nxt_shift = r_shift_step;
    w_nxt_last  = r_last_step;
    w_nxt_busy  = r_busy;
    if (bus.flush) begin
      w_nxt_state = IDLE;
      w_nxt_cnt   = '0;
      w_nxt_valid = 1'b0;
      w_nxt_shift = 1'b0;
      w_nxt_last  = 1'b0;
      w_nxt_busy  = 1'b0;
    end else if (!bus.stall) begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            w_nxt_valid = 1'b1;
            // illegal classes always present a zero control code
            w_nxt_ctrl  = w_dec_illegal ? '0 : w_dec_ctrl;
            if (w_is_shift && (bus.shamt != '0)) begin
              w_nxt_state = SHIFT;
              w_nxt_cnt   = bus.shamt;
              w_nxt_shift = 1'b1;
              w_nxt_last  = (bus.shamt == SHAMT_W'(1));
              w_nxt_busy  = 1'b1;
            end else begin
              w_nxt_shift = 1'b0;
              w_nxt_last  = 1'b1;
              w_nxt_busy  = 1'b0;
            end
          end else begin
            w_nxt_valid = 1'b0;
            w_nxt_shift = 1'b0;
            w_nxt_last  = 1'b0;
            w_nxt_busy  = 1'b0;
          end
        end
        SHIFT: begin
          if (r_cnt <= SHAMT_W'(1)) begin
            w_nxt_state = IDLE;
            w_nxt_cnt   = '0;
            w_nxt_valid = 1'b0;
            w_nxt_shift = 1'b0;
            w_nxt_last  = 1'b0;
            w_nxt_busy  = 1'b0;
          end else begin
            w_nxt_cnt   = r_cnt - SHAMT_W'(1);
            w_nxt_valid = 1'b1;
            w_nxt_shift = 1'b1;
            w_nxt_last  = (r_cnt == SHAMT_W'(2));
            w_nxt_busy  = 1'b1;
          end
        end
      endcase
    end
  end

  // state, counter and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_out_valid  <= 1'b0;
      r_alu_ctrl   <= '0;
      r_shift_step <= 1'b0;
      r_last_step  <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_nxt_state;
      r_cnt        <= w_nxt_cnt;
      r_out_valid  <= w_nxt_valid;
      r_alu_ctrl   <= w_nxt_ctrl;
      r_shift_step <= w_nxt_shift;
      r_last_step  <= w_nxt_last;
      r_busy       <= w_nxt_busy;
    end
  end

`ifdef ALU_CTRL_SEQ_ILLEGAL_TRAP_EN
  logic r_illegal;

  // sticky trap on accepting an illegal class; only flush or reset clears it
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_illegal <= 1'b0;
    end else if (bus.flush) begin
      r_illegal <= 1'b0;
    end else if (w_accept && w_dec_illegal) begin
      r_illegal <= 1'b1;
    end
  end

  assign bus.illegalOp = r_illegal;
`else
  assign bus.illegalOp = 1'b0;
`endif

  assign bus.inReady    = w_in_ready;
  assign bus.outValid   = r_out_valid;
  assign bus.aluControl = r_alu_ctrl;
  assign bus.shiftStep  = r_shift_step;
  assign bus.lastStep   = r_last_step;
  assign bus.busy       = r_busy;

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// tb_alu_ctrl_seq: directed scenarios plus randomized traffic, compared
// cycle by cycle against a beat-queue reference model.
module tb_alu_ctrl_seq;
  localparam int OP_W    = 3;
  localparam int FUNC_W  = 3;
  localparam int CTRL_W  = 4;
  localparam int SHAMT_W = 4;
`ifdef ALU_CTRL_SEQ_ILLEGAL_TRAP_EN
  localparam int ILL_EN = 1;
`else
  localparam int ILL_EN = 0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_ctrl_seq_if #(.OP_W(OP_W), .FUNC_W(FUNC_W), .CTRL_W(CTRL_W), .SHAMT_W(SHAMT_W)) bus ();

  alu_ctrl_seq #(.OP_W(OP_W), .FUNC_W(FUNC_W), .CTRL_W(CTRL_W), .SHAMT_W(SHAMT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    int ctrl;
    bit shift;
    bit last;
  } beat_t;

  beat_t q[$];
  int m_valid = 0, m_ctrl = 0, m_shift = 0, m_last = 0, m_ill = 0;
  int n_checks = 0, n_errors = 0;
  int beat_cnt = 0, last_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input int exp);
    n_checks++;
    if (obs !== 32'(exp)) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int ref_ctrl(input int op, input int fn, input bit dir);
    case (op)
      0: return 0;
      1: return 1;
      2: return fn;
      3: return dir ? 6 : 7;
      4: return 8;
      default: return 0;
    endcase
  endfunction

  // ready whenever no beats are pending and no shift beat is on display
  function automatic int model_ready();
    return (rst_n && q.size() == 0 && m_shift == 0 && !bus.stall && !bus.flush) ? 1 : 0;
  endfunction

  task automatic model_clock();
    int op, sh, c;
    beat_t b;
    if (!rst_n) begin
      q.delete();
      m_valid = 0; m_ctrl = 0; m_shift = 0; m_last = 0; m_ill = 0;
    end else if (bus.flush) begin
      q.delete();
      m_valid = 0; m_shift = 0; m_last = 0; m_ill = 0;
    end else if (!bus.stall) begin
      if (bus.inValid && model_ready() == 1) begin
        op = int'(bus.aluOp);
        sh = int'(bus.shamt);
        c  = ref_ctrl(op, int'(bus.func), bus.shiftDirection);
        if (op >= 5 && ILL_EN == 1) m_ill = 1;
        if (op == 3 && sh > 0) begin
          for (int k = 1; k <= sh; k++) q.push_back('{c, 1'b1, (k == sh)});
        end else begin
          q.push_back('{c, 1'b0, 1'b1});
        end
      end
      if (q.size() > 0) begin
        b = q.pop_front();
        m_valid = 1; m_ctrl = b.ctrl; m_shift = int'(b.shift); m_last = int'(b.last);
      end else begin
        m_valid = 0; m_shift = 0; m_last = 0;
      end
    end
  endtask

  // drive at negedge, check ready, advance model at posedge, check outputs at negedge
  task automatic step(input bit rn, input bit iv, input int op, input int fn,
                      input bit dir, input int sh, input bit st, input bit fl);
    rst_n              = rn;
    bus.inValid        = iv;
    bus.aluOp          = OP_W'(op);
    bus.func           = FUNC_W'(fn);
    bus.shiftDirection = dir;
    bus.shamt          = SHAMT_W'(sh);
    bus.stall          = st;
    bus.flush          = fl;
    #1;
    chk("inReady", bus.inReady, model_ready());
    @(posedge clk);
    model_clock();
    @(negedge clk);
    chk("outValid",   bus.outValid,   m_valid);
    chk("aluControl", bus.aluControl, m_ctrl);
    chk("shiftStep",  bus.shiftStep,  m_shift);
    chk("lastStep",   bus.lastStep,   m_last);
    chk("busy",       bus.busy,       m_shift);
    chk("illegalOp",  bus.illegalOp,  m_ill);
    if (!st && bus.outValid && bus.shiftStep) beat_cnt++;
    if (!st && bus.outValid && bus.lastStep) last_cnt++;
  endtask

  task automatic idle();
    step(1'b1, 1'b0, 0, 0, 1'b0, 0, 1'b0, 1'b0);
  endtask

  initial begin
    // reset held with a pending op
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1, 0, 1'b0, 0, 1'b0, 1'b0);
    idle();

    // back-to-back single-beat ops
    step(1'b1, 1'b1, 0, 0, 1'b0, 0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1, 0, 1'b0, 0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 2, 5, 1'b0, 0, 1'b0, 1'b0);
    chk("b2b_func", bus.aluControl, 5);
    idle();

    // shift right by 3, then shift left by 0
    beat_cnt = 0; last_cnt = 0;
    step(1'b1, 1'b1, 3, 0, 1'b1, 3, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) idle();
    chk("shr3_beats", beat_cnt, 3);
    chk("shr3_last", last_cnt, 1);
    step(1'b1, 1'b1, 3, 0, 1'b0, 0, 1'b0, 1'b0);
    chk("shl0_ctrl", bus.aluControl, 7);
    idle();

    // stall for two cycles after beat 2 of a 4-beat shift
    beat_cnt = 0; last_cnt = 0;
    step(1'b1, 1'b1, 3, 0, 1'b1, 4, 1'b0, 1'b0);
    idle();
    step(1'b1, 1'b1, 0, 0, 1'b0, 0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 0, 0, 1'b0, 0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) idle();
    chk("stall_beats", beat_cnt, 4);
    chk("stall_last", last_cnt, 1);

    // flush on beat 5 of a 15-beat shift, then flush with a valid op
    step(1'b1, 1'b1, 3, 0, 1'b0, 15, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) idle();
    step(1'b1, 1'b0, 0, 0, 1'b0, 0, 1'b0, 1'b1);
    chk("flush_valid", bus.outValid, 0);
    step(1'b1, 1'b1, 4, 0, 1'b0, 0, 1'b0, 1'b1);
    chk("flush_noacc", bus.outValid, 0);
    idle();

    // illegal class, sticky flag until flush
    step(1'b1, 1'b1, 6, 3, 1'b0, 0, 1'b0, 1'b0);
    idle();
    step(1'b1, 1'b1, 4, 0, 1'b0, 0, 1'b0, 1'b0);
    chk("ill_sticky", bus.illegalOp, ILL_EN);
    step(1'b1, 1'b0, 0, 0, 1'b0, 0, 1'b0, 1'b1);
    idle();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bit rn, iv, dir, st, fl;
      int op, fn, sh;
      rn  = ($urandom_range(0, 199) != 0);
      iv  = ($urandom_range(0, 3) != 0);
      op  = $urandom_range(0, 7);
      fn  = $urandom_range(0, 7);
      dir = 1'($urandom_range(0, 1));
      sh  = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 3);
      st  = ($urandom_range(0, 9) == 0);
      fl  = ($urandom_range(0, 29) == 0);
      step(rn, iv, op, fn, dir, sh, st, fl);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
